rf_port_master: RTL
===================

# rf_port_master

Initiator for the general-purpose register-file port: accepts decoded instructions, sequences the registered read ports, captures operands and hands them to execute; in parallel it converts writeback requests into negedge write strobes. A 32-entry busy scoreboard stalls reads of registers with writebacks outstanding. It sits between decode/execute/writeback and `universal_reg_group`-style storage: `WRR[2]` is the write enable, `WRR[1]` and `WRR[0]` are the read enables, reads are registered on posedge and writes happen on negedge.

## Interface
- `XLEN`, default 64: data width.
- `AW`, default 5: register address width (32 registers).
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `dec_valid` in 1, `dec_ready` out 1: decode handshake.
- `dec_rs1`, `dec_rs2`, `dec_rd` in AW: source and destination register indices.
- `dec_use_rs1`, `dec_use_rs2`, `dec_wen` in 1: operand-used flags and writes-rd flag.
- `op_valid` out 1, `op_ready` in 1: execute handshake.
- `op_rs1_data`, `op_rs2_data` out XLEN: captured operands.
- `op_rd` out AW, `op_wen` out 1: forwarded destination information.
- `wb_valid` in 1, `wb_ready` out 1: writeback handshake.
- `wb_rd` in AW, `wb_data` in XLEN: writeback request.
- `rf_raddr1`, `rf_raddr2`, `rf_waddr` out AW: register-file addresses.
- `rf_wrr` out 3: {write, read1, read2} enables.
- `rf_wdata` out XLEN: write data.
- `rf_rdata1`, `rf_rdata2` in XLEN: registered read data.
- `stall_cnt` out 32: saturating count of hazard-stall cycles.

## Operation
- FSM states are IDLE, READ, CAPT and OUT.
- **IDLE:** `dec_ready`=1. When `dec_valid` is high, latch rs1/rs2/rd and the three flags, then go to READ.
- **READ:**
  - hazard = (use_rs1 & rs1≠0 & busy[rs1] & ¬clr1) | (same condition for rs2), where clrN = wb fire & wb_rd==rsN.
  - On hazard: stay in READ, drive no read enables, and increment `stall_cnt`, saturating at 0xFFFF_FFFF.
  - Otherwise: drive `rf_raddr1/2` and set `rf_wrr[1]`=use_rs1, `rf_wrr[0]`=use_rs2 for exactly this one cycle, then go to CAPT.
- **CAPT:** register `rf_rdata1/2` into the operand outputs. An operand is forced to 0 if its source register is x0 or it is unused. Go to OUT.
- **OUT:** `op_valid`=1, with operands, `op_rd` and `op_wen` held stable. On `op_ready`: if op_wen & rd≠0, set busy[rd]; go to IDLE.
- **Writeback path** (independent of the FSM):
  - `wb_ready`=1 whenever `rst`=0.
  - `rf_waddr`=`wb_rd` and `rf_wdata`=`wb_data`, both combinational.
  - `rf_wrr[2]` = wb_valid & wb_ready & wb_rd≠0; writes to x0 are suppressed.
  - On fire, clear busy[wb_rd].
- **Scoreboard:**
  - A set and a clear of the same index in the same cycle: the set wins (the new producer is outstanding).
  - A writeback to a non-busy register is still written; busy stays 0.
  - busy[0] is never set.

## Timing
- The read enable is asserted in cycle N, the file registers data at the end of N, the master captures in N+1 (CAPT), and `op_valid` rises in N+2.
- Minimum latency from `dec_valid` accepted to `op_valid` is 3 cycles. Throughput is at most one instruction per 4 cycles.
- A write strobed in cycle N commits at the negedge inside N. A read enabled in the same cycle N therefore returns the new value. This is why clrN removes the hazard in the same cycle.
- Reset values: state IDLE, busy all 0, `op_valid`=0, operands/`op_rd`/`op_wen` 0, `stall_cnt`=0.
- While `rst`=1: `dec_ready`=0, `wb_ready`=0, `rf_wrr`=0.
- Reset mid-operation discards the latched instruction and all outstanding busy bits.
- `op_valid` must not drop, and its payload must not change, until `op_ready`.

## Structure
- Package `rf_pkg` holds:
  - `XLEN`, `AW`, `NREG`=32;
  - WRR bit indices `WRR_RD`=2, `WRR_RS1`=1, `WRR_RS2`=0;
  - the FSM state enum `rfm_state_t`.
- Sub-module `rf_scoreboard` holds the 32-bit busy vector with set/clear ports (set priority) and two combinational query ports.
- The top level holds the FSM, the operand registers and the stall counter.

## Test plan
- **Basic read:** preload x5=0x1111, x6=0x2222; issue rs1=5, rs2=6, rd=7, wen=1 → `rf_wrr`=3'b011 for one cycle, `op_valid` 3 cycles after accept, operands 0x1111/0x2222; after `op_ready`, busy[7]=1.
- **RAW stall:** with busy[7]=1, issue rs1=7 → stays in READ, `stall_cnt` increments each cycle; wb rd=7 data=0xABCD → `rf_wrr`=3'b110 that cycle, op_rs1_data=0xABCD, stall count equals the cycles waited.
- **x0 handling:** wb rd=0 data=0xFFFF → `rf_wrr[2]`=0; read rs1=0 → op_rs1_data=0; dec_rd=0 with wen=1 → busy stays 0.
- **Back-pressure:** hold `op_ready`=0 for 5 cycles → `op_valid` and payload stable, `dec_ready`=0; a concurrent wb to x9 is still written.
- **Set/clear collision:** the OUT handshake sets rd=3 in the same cycle as wb rd=3 → busy[3]=1 afterwards.
- **Reset mid-operation:** assert `rst` in CAPT with busy[4]=1 → next cycle `op_valid`=0, busy all 0, `stall_cnt`=0, `rf_wrr`=0.

Source files
------------

// File: rtl/rf_port_master_pkg.sv
// rf_pkg: shared constants and types for the register-file port master.
//   XLEN / AW / NREG  : default data width, address width, register count
//   WRR_*             : bit positions inside the {write, read1, read2} strobe
//   rfm_state_t       : sequencing FSM states
package rf_pkg;

   localparam int XLEN = 64;
   localparam int AW   = 5;
   localparam int NREG = 32;

   localparam int WRR_RD  = 2;
   localparam int WRR_RS1 = 1;
   localparam int WRR_RS2 = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      CAPT = 2'd2,
      OUT  = 2'd3
   } rfm_state_t;

   // x0 is hardwired zero: never a hazard, never tracked, never written.
   function automatic logic is_x0(input logic [AW-1:0] idx);
      return (idx == '0);
   endfunction

endpackage

// File: rtl/rf_port_master_if.sv
// rf_port_master_if: bundles the decode, execute, writeback and register-file
// buses seen by rf_port_master.
//   master modport : the rf_port_master view
//   slave  modport : the surrounding pipeline / storage view
interface rf_port_master_if #(
   parameter int XLEN = 64,
   parameter int AW   = 5
);
   // decode
   logic            dec_valid;
   logic            dec_ready;
   logic [AW-1:0]   dec_rs1;
   logic [AW-1:0]   dec_rs2;
   logic [AW-1:0]   dec_rd;
   logic            dec_use_rs1;
   logic            dec_use_rs2;
   logic            dec_wen;
   // execute
   logic            op_valid;
   logic            op_ready;
   logic [XLEN-1:0] op_rs1_data;
   logic [XLEN-1:0] op_rs2_data;
   logic [AW-1:0]   op_rd;
   logic            op_wen;
   // writeback
   logic            wb_valid;
   logic            wb_ready;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   // register file
   logic [AW-1:0]   rf_raddr1;
   logic [AW-1:0]   rf_raddr2;
   logic [AW-1:0]   rf_waddr;
   logic [2:0]      rf_wrr;
   logic [XLEN-1:0] rf_wdata;
   logic [XLEN-1:0] rf_rdata1;
   logic [XLEN-1:0] rf_rdata2;

   modport master (
      input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_wen,
      output dec_ready,
      output op_valid, op_rs1_data, op_rs2_data, op_rd, op_wen,
      input  op_ready,
      input  wb_valid, wb_rd, wb_data,
      output wb_ready,
      output rf_raddr1, rf_raddr2, rf_waddr, rf_wrr, rf_wdata,
      input  rf_rdata1, rf_rdata2
   );

   modport slave (
      output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_wen,
      input  dec_ready,
      input  op_valid, op_rs1_data, op_rs2_data, op_rd, op_wen,
      output op_ready,
      output wb_valid, wb_rd, wb_data,
      input  wb_ready,
      input  rf_raddr1, rf_raddr2, rf_waddr, rf_wrr, rf_wdata,
      output rf_rdata1, rf_rdata2
   );

endinterface

// File: rtl/rf_port_master_scoreboard.sv
// rf_scoreboard: busy bit per register, set when an instruction that writes rd
// is handed to execute, cleared when its writeback fires.
//   clk, rst          : clock, synchronous active-high reset (clears all bits)
//   set_en / set_idx  : mark a register as having a pending producer
//   clr_en / clr_idx  : writeback completed for a register
//   q_idx1/2, q_busy1/2 : combinational busy lookups for the two read ports
module rf_scoreboard #(
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_idx,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_idx,
   input  logic [AW-1:0] q_idx1,
   input  logic [AW-1:0] q_idx2,
   output logic          q_busy1,
   output logic          q_busy2
);

   logic [NREG-1:0] busy;

   // Set beats clear on the same index: the newly issued producer is still
   // outstanding even though an older write to that register just landed.
   // Bit 0 stays zero because x0 never has a producer.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (set_en && set_idx == AW'(i))
               busy[i] <= 1'b1;
            else if (clr_en && clr_idx == AW'(i))
               busy[i] <= 1'b0;
         end
         busy[0] <= 1'b0;
      end
   end

   assign q_busy1 = busy[q_idx1];
   assign q_busy2 = busy[q_idx2];

endmodule

// File: rtl/rf_port_master.sv
// rf_port_master: sequences register-file reads for decoded instructions and
// hands captured operands to execute; independently turns writeback requests
// into write strobes. A busy scoreboard holds reads of registers whose
// writeback is still outstanding.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : decode / execute / writeback / register-file signals
//   stall_cnt  : saturating count of cycles spent waiting on a hazard
module rf_port_master #(
   parameter int XLEN = rf_pkg::XLEN,
   parameter int AW   = rf_pkg::AW
) (
   input  logic               clk,
   input  logic               rst,
   rf_port_master_if.master   bus,
   output logic [31:0]        stall_cnt
);
   import rf_pkg::*;

   rfm_state_t    state, state_nxt;

   logic [AW-1:0] rs1_q, rs2_q, rd_q;
   logic          use1_q, use2_q, wen_q;

   logic          idle_rdy, latch, capt, stall_inc;
   logic          rd_en1, rd_en2;
   logic          wb_fire, clr1, clr2, busy1, busy2, hazard, set_en;

   // ---------------- writeback path ----------------
   assign bus.wb_ready = ~rst;
   assign wb_fire      = bus.wb_valid & ~rst;
   assign bus.rf_waddr = bus.wb_rd;
   assign bus.rf_wdata = bus.wb_data;

   // The file writes on the negedge, so a read enabled in the same cycle as a
   // writeback already sees the new value: a matching writeback lifts the
   // hazard immediately instead of costing another cycle.
   assign clr1   = wb_fire && (bus.wb_rd == rs1_q);
   assign clr2   = wb_fire && (bus.wb_rd == rs2_q);
   assign hazard = (use1_q && !is_x0(rs1_q) && busy1 && !clr1) ||
                   (use2_q && !is_x0(rs2_q) && busy2 && !clr2);

   assign set_en = (state == OUT) && bus.op_ready && wen_q && !is_x0(rd_q);

   rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
      .clk     (clk),
      .rst     (rst),
      .set_en  (set_en),
      .set_idx (rd_q),
      .clr_en  (wb_fire),
      .clr_idx (bus.wb_rd),
      .q_idx1  (rs1_q),
      .q_idx2  (rs2_q),
      .q_busy1 (busy1),
      .q_busy2 (busy2)
   );

   // ---------------- sequencing FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      idle_rdy  = 1'b0;
      latch     = 1'b0;
      capt      = 1'b0;
      stall_inc = 1'b0;
      rd_en1    = 1'b0;
      rd_en2    = 1'b0;
      case (state)
         IDLE: begin
            idle_rdy = 1'b1;
            if (bus.dec_valid) begin
               latch     = 1'b1;
               state_nxt = READ;
            end
         end
         READ: begin
            if (hazard) begin
               stall_inc = 1'b1;
            end else begin
               rd_en1    = use1_q;
               rd_en2    = use2_q;
               state_nxt = CAPT;
            end
         end
         CAPT: begin
            capt      = 1'b1;
            state_nxt = OUT;
         end
         OUT: begin
            if (bus.op_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.dec_ready = idle_rdy & ~rst;

   always_comb begin
      bus.rf_wrr          = '0;
      bus.rf_wrr[WRR_RD]  = wb_fire && !is_x0(bus.wb_rd);
      bus.rf_wrr[WRR_RS1] = rd_en1 & ~rst;
      bus.rf_wrr[WRR_RS2] = rd_en2 & ~rst;
   end

   assign bus.rf_raddr1 = rs1_q;
   assign bus.rf_raddr2 = rs2_q;

   // ---------------- instruction latch ----------------
   // Loaded only in IDLE, so op_rd/op_wen cannot move while op_valid is up.
   always_ff @(posedge clk) begin
      if (rst) begin
         rs1_q  <= '0;
         rs2_q  <= '0;
         rd_q   <= '0;
         use1_q <= 1'b0;
         use2_q <= 1'b0;
         wen_q  <= 1'b0;
      end else if (latch) begin
         rs1_q  <= bus.dec_rs1;
         rs2_q  <= bus.dec_rs2;
         rd_q   <= bus.dec_rd;
         use1_q <= bus.dec_use_rs1;
         use2_q <= bus.dec_use_rs2;
         wen_q  <= bus.dec_wen;
      end
   end

   // ---------------- operand capture ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.op_rs1_data <= '0;
         bus.op_rs2_data <= '0;
      end else if (capt) begin
         bus.op_rs1_data <= (use1_q && !is_x0(rs1_q)) ? bus.rf_rdata1 : '0;
         bus.op_rs2_data <= (use2_q && !is_x0(rs2_q)) ? bus.rf_rdata2 : '0;
      end
   end

   assign bus.op_valid = (state == OUT);
   assign bus.op_rd    = rd_q;
   assign bus.op_wen   = wen_q;

   // ---------------- hazard stall counter ----------------
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall_inc && stall_cnt != 32'hFFFF_FFFF)
         stall_cnt <= stall_cnt + 32'd1;
   end

endmodule
